// File: rtl/seq_det_pkg.sv
// Shared types for the multi-channel serial sequence detector.
// Latency: n/a (types only).
// Backpressure: n/a.
package seq_det_pkg;

    typedef enum logic {IDLE, RUN} seq_det_state_e;

    typedef enum logic {MODE_COUNT, MODE_PATTERN} seq_det_mode_e;

endpackage

// File: rtl/seq_det_chan.sv
// One detector lane: IDLE/RUN FSM, config shadow, ones counter, pattern history, fill level.
// Latency: dout is combinational from din/din_valid (Mealy, 0 cycles).
// Backpressure: none; din_valid low freezes the lane, soft_clr forces it back to IDLE.
//
// Optional macro SEQ_DET_MATCH_CNT_EN adds a saturating per-lane match counter;
// without it match_cnt is tied to zero and no counter flops exist.
//
// Ports: clk/rst (sync, active-low), soft_clr, cfg_* (sampled in IDLE only),
//        din_valid/din (serial input), dout (match pulse), active (in RUN), match_cnt.
module seq_det_chan
    import seq_det_pkg::*;
#(
    parameter  int PAT_W  = 8,
    parameter  int CNT_W  = 4,
    parameter  int MCNT_W = 16,
    localparam int LEN_W  = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_clr,
    input  logic              cfg_mode,
    input  logic [CNT_W-1:0]  cfg_k,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              din_valid,
    input  logic              din,
    output logic              dout,
    output logic              active,
    output logic [MCNT_W-1:0] match_cnt
);

    seq_det_state_e     state_q, state_d;
    seq_det_mode_e      mode_q,  mode_d;
    logic [CNT_W-1:0]   k_q,     k_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic [PAT_W-1:0]   pat_q,   pat_d;
    logic [CNT_W-1:0]   ones_q,  ones_d;
    logic [PAT_W-2:0]   hist_q,  hist_d;
    logic [LEN_W-1:0]   fill_q,  fill_d;

    logic [CNT_W-1:0]   keff;
    logic [LEN_W-1:0]   leff;
    logic [PAT_W-1:0]   window;
    logic [PAT_W-1:0]   mask;
    logic               cnt_hit;
    logic               pat_hit;
    logic               match;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        k_d     = k_q;
        len_d   = len_q;
        pat_d   = pat_q;
        ones_d  = ones_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match   = 1'b0;

        // K of 0 behaves as K of 1; length is clamped into 1..PAT_W.
        keff = (k_q == '0) ? CNT_W'(1) : k_q;
        if (len_q == '0) begin
            leff = LEN_W'(1);
        end else if (len_q > LEN_W'(PAT_W)) begin
            leff = LEN_W'(PAT_W);
        end else begin
            leff = len_q;
        end

        // Window includes the bit arriving this cycle so a match is flagged in the same cycle.
        window = {hist_q, din};
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(leff));
        end
        pat_hit = (((window ^ pat_q) & mask) == '0) && (fill_q >= (leff - LEN_W'(1)));
        cnt_hit = din && (ones_q == (keff - CNT_W'(1)));

        case (state_q)
            IDLE: begin
                mode_d  = seq_det_mode_e'(cfg_mode);
                k_d     = cfg_k;
                len_d   = cfg_len;
                pat_d   = cfg_pattern;
                ones_d  = '0;
                hist_d  = '0;
                fill_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                if (din_valid) begin
                    if (mode_q == MODE_COUNT) begin
                        match = cnt_hit;
                        if (din) begin
                            ones_d = cnt_hit ? '0 : ones_q + CNT_W'(1);
                        end
                    end else begin
                        match  = pat_hit;
                        // History is never cleared on a match, so overlapping patterns hit.
                        hist_d = window[PAT_W-2:0];
                        if (fill_q != LEN_W'(PAT_W)) begin
                            fill_d = fill_q + LEN_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (soft_clr) begin
            state_d = IDLE;
            match   = 1'b0;
        end

        dout = match & rst;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_COUNT;
            k_q     <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            ones_q  <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            ones_q  <= ones_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    assign active = (state_q == RUN);

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;

    // Saturating; survives soft_clr, cleared only by rst.
    always_comb begin
        mcnt_d = mcnt_q;
        if (dout && (mcnt_q != '1)) begin
            mcnt_d = mcnt_q + MCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcnt_q <= '0;
        end else begin
            mcnt_q <= mcnt_d;
        end
    end

    assign match_cnt = mcnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: rtl/seq_det_multi.sv
// Multi-channel serial detector: CHANNELS independent lanes sharing one config bus.
// Latency: dout is combinational from din/din_valid (Mealy, 0 cycles).
// Backpressure: none; per-lane din_valid low holds that lane, soft_clr restarts all lanes.
//
// Optional macro SEQ_DET_MATCH_CNT_EN enables the per-lane match counters (else match_cnt = 0).
//
// Ports: clk/rst (sync, active-low), soft_clr, cfg_mode/cfg_k/cfg_len/cfg_pattern (shared),
//        din_valid/din/dout/active (one bit per lane), match_cnt (MCNT_W bits per lane, lane 0 LSBs).
module seq_det_multi
    import seq_det_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int PAT_W    = 8,
    parameter  int CNT_W    = 4,
    parameter  int MCNT_W   = 16,
    localparam int LEN_W    = $clog2(PAT_W + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       soft_clr,
    input  logic                       cfg_mode,
    input  logic [CNT_W-1:0]           cfg_k,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [CHANNELS-1:0]        din_valid,
    input  logic [CHANNELS-1:0]        din,
    output logic [CHANNELS-1:0]        dout,
    output logic [CHANNELS-1:0]        active,
    output logic [CHANNELS*MCNT_W-1:0] match_cnt
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        seq_det_chan #(
            .PAT_W  (PAT_W),
            .CNT_W  (CNT_W),
            .MCNT_W (MCNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .soft_clr    (soft_clr),
            .cfg_mode    (cfg_mode),
            .cfg_k       (cfg_k),
            .cfg_len     (cfg_len),
            .cfg_pattern (cfg_pattern),
            .din_valid   (din_valid[g]),
            .din         (din[g]),
            .dout        (dout[g]),
            .active      (active[g]),
            .match_cnt   (match_cnt[g*MCNT_W +: MCNT_W])
        );
    end

endmodule
